// File: rtl/m_clk_div_sel_if.sv
// Select-request handshake between a requester and the clock divider/select sequencer.
interface m_clk_div_sel_if;
    logic       sel_req_valid;
    logic [1:0] sel_req;
    logic       sel_req_ready;
    logic       sel_ack;
    logic [1:0] sel_o;

    modport master (
        output sel_req_valid,
        output sel_req,
        input  sel_req_ready,
        input  sel_ack,
        input  sel_o
    );

    modport slave (
        input  sel_req_valid,
        input  sel_req,
        output sel_req_ready,
        output sel_ack,
        output sel_o
    );
endinterface

// File: rtl/m_clk_div_sel.sv
// Divided-clock generator (div2/4/8) and glitch-safe 4:1 clock-mux select sequencer.
// Select updates land on the counter wrap edge, where all divided clocks fall together.
module m_clk_div_sel #(
    parameter logic [1:0]  RESET_SEL  = 2'd0,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 div_en,
    m_clk_div_sel_if.slave       bus,
    output logic                 clk_div2,
    output logic                 clk_div4,
    output logic                 clk_div8,
    output logic                 busy
);

    localparam int unsigned CNT_W    = 3;
    localparam int unsigned SETTLE_W = 4;
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(7);
    // Settle counter counts down to zero, so load one less than the cycle count.
    localparam logic [SETTLE_W-1:0] SETTLE_LD =
        (SETTLE_CYC == 0) ? SETTLE_W'(0) : SETTLE_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SETTLE  = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [1:0]          pend_sel, pend_sel_d;
    logic [1:0]          sel_d;
    logic [SETTLE_W-1:0] settle_cnt, settle_d;
    logic                ack_d;
    logic                ready_d;
    logic                busy_d;
    logic                accept_c;
    logic                apply_c;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cnt               <= '0;
            pend_sel          <= '0;
            settle_cnt        <= '0;
            bus.sel_o         <= RESET_SEL;
            bus.sel_ack       <= 1'b0;
            bus.sel_req_ready <= 1'b0;
            busy              <= 1'b0;
        end else begin
            state             <= state_d;
            cnt               <= cnt_d;
            pend_sel          <= pend_sel_d;
            settle_cnt        <= settle_d;
            bus.sel_o         <= sel_d;
            bus.sel_ack       <= ack_d;
            bus.sel_req_ready <= ready_d;
            busy              <= busy_d;
        end
    end

    // Divided clocks are the counter flops themselves.
    assign clk_div2 = cnt[0];
    assign clk_div4 = cnt[1];
    assign clk_div8 = cnt[2];

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        cnt_d      = div_en ? cnt + CNT_W'(1) : cnt;
        pend_sel_d = pend_sel;
        sel_d      = bus.sel_o;
        settle_d   = settle_cnt;
        ack_d      = 1'b0;

        accept_c = (state == IDLE) && bus.sel_req_ready && bus.sel_req_valid;
        // Uses the sampled div_en/cnt so the apply edge is the 7->0 wrap or a frozen counter.
        apply_c  = !div_en || (cnt == CNT_LAST);

        unique case (state)
            IDLE: begin
                if (accept_c) begin
                    pend_sel_d = bus.sel_req;
                    state_d    = PENDING;
                end
            end
            PENDING: begin
                if (apply_c) begin
                    sel_d    = pend_sel;
                    ack_d    = 1'b1;
                    settle_d = SETTLE_LD;
                    state_d  = (SETTLE_CYC == 0) ? IDLE : SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    settle_d = settle_cnt - SETTLE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

endmodule

// File: doc/m_clk_div_sel.md
Name: m_clk_div_sel

Overview:
- Clock-source generator and select sequencer that sits directly upstream of the 4:1 std-cell clock mux.
- Produces divided clocks for the mux data inputs: A = raw clk (external), B = div2, C = div4, D = div8.
- Produces the 2-bit mux select through a request/ack handshake.
- The select changes only on the edge where all divided clocks fall together, or while the dividers are frozen.

Parameters:
- RESET_SEL, 2'd0: value of sel_o after reset.
- SETTLE_CYC, 2: cycles after a select change during which new requests are refused; legal range 0..15.

Ports:
- clk  input  1  reference clock; also drives mux input A externally.
- rst_n  input  1  asynchronous active-low reset.
- div_en  input  1  divider counter enable; counter holds when 0.
- sel_req_valid  input  1  select change request valid.
- sel_req  input  2  requested select: 0=clk, 1=div2, 2=div4, 3=div8.
- sel_req_ready  output  1  request accepted when valid & ready.
- sel_ack  output  1  one-cycle pulse on the cycle sel_o takes the requested value.
- sel_o  output  2  registered select; drives mux S[1:0].
- clk_div2  output  1  clk/2, flop output.
- clk_div4  output  1  clk/4, flop output.
- clk_div8  output  1  clk/8, flop output.
- busy  output  1  high in PENDING or SETTLE.

Behaviour:

Reset:
- Reset is asynchronous, active-low. On rst_n=0, all outputs go immediately to their reset values:
  - cnt=0; clk_div2/4/8=0
  - sel_o=RESET_SEL; sel_ack=0; sel_req_ready=0; busy=0
  - state=IDLE; settle counter=0
- Reset mid-request or mid-settle discards the pending request; no ack is issued.
- First cycle after rst_n deasserts: sel_req_ready=1.

Divider:
- 3-bit cnt; on each rising clk with div_en=1, cnt<=cnt+1, wrapping 7->0.
- clk_div2=cnt[0], clk_div4=cnt[1], clk_div8=cnt[2]. These are the cnt flops themselves; no combinational logic on the outputs.
- div_en=0: cnt and all divided clocks hold their value.
- The wrap edge (cnt 7->0) is the only edge where all three divided clocks fall simultaneously. This is the aligned point.

Select FSM, states IDLE / PENDING / SETTLE:
- IDLE:
  - sel_req_ready=1.
  - valid&ready: latch sel_req into pend_sel and go to PENDING.
- PENDING:
  - sel_req_ready=0; new requests are not accepted and are not lost by the block; the requester holds valid.
  - Apply condition: (div_en=1 and cnt==7) or div_en=0.
  - On the apply edge: sel_o<=pend_sel, sel_ack<=1 for exactly one cycle.
  - Then go to SETTLE, or to IDLE if SETTLE_CYC=0.
  - With div_en=1, sel_o therefore changes on the same edge as the 7->0 wrap.
  - With div_en=0, sel_o changes one cycle after acceptance.
- SETTLE:
  - Counts SETTLE_CYC cycles (4-bit counter, loaded on the apply edge), then goes to IDLE.
  - sel_req_ready=0 throughout.
- Request equal to the current sel_o:
  - Processed normally: wait for the aligned point, ack pulse, settle.
  - sel_o is rewritten with the same value, so no visible change.
- div_en falling while in PENDING: apply on the next edge; the counter is frozen, so there is no phase hazard.
- div_en rising on the same edge where cnt would be 7: the apply condition uses the sampled div_en and cnt values, not the next-state values.
- busy = (state != IDLE).

Latency:
- Acceptance to ack is 1..8 cycles with div_en=1.
  - Accept at cnt==7: the apply waits for the next cnt==7, i.e. 8 cycles later. The accept edge itself never applies.
- Acceptance to ack is 1 cycle with div_en=0.

Test Plan:
1. Reset, then div_en=1 and free-run 32 cycles -> clk_div2/4/8 have periods 2/4/8; all three fall together every 8 cycles; sel_o=RESET_SEL=0; busy=0.
2. Request sel=2, accepted at cnt==3 -> ack asserts on the edge where cnt goes 7->0 (4 cycles later); sel_o=2 from that edge; ready=0 for the next 2 settle cycles, then 1.
3. Request accepted exactly at cnt==7 -> no apply on that edge; ack occurs 8 cycles later at the next 7->0 wrap.
4. div_en=0 with cnt held at 5, request sel=3 -> ack and sel_o=3 one cycle after acceptance; cnt stays 5; clk_div2/4/8 stay 1/0/1.
5. Request sel=1 held valid during SETTLE -> not accepted until state returns to IDLE; then accepted, and sel_o=1 at the next wrap.
6. rst_n pulsed low while PENDING with pend_sel=3 -> outputs go to reset values immediately (sel_o=0, cnt=0); no ack after release; ready=1 on the first cycle after release.
